// File: rtl/decoder_scan_sequencer_pkg.sv
// Shared definitions for the 2x4 decoder scan sequencer.
//   state_e   : FSM state encoding (3-bit)
//   AddrLast  : final decoder address of a pass
package decoder_scan_sequencer_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StSetup  = 3'd1,
    StActive = 3'd2,
    StBlank  = 3'd3,
    StDone   = 3'd4
  } state_e;

  localparam logic [1:0] AddrLast = 2'b11;

endpackage

// File: rtl/decoder_scan_sequencer_dwell_timer.sv
// Dwell down-counter for one ACTIVE window.
//   clock, reset : clock and asynchronous active-high reset
//   load         : load value (asserted in the cycle before ACTIVE)
//   run          : count down (asserted while ACTIVE)
//   value        : dwell length in cycles, must be non-zero
//   expire       : high on the final ACTIVE cycle of the window
module decoder_scan_sequencer_dwell_timer #(
  parameter int unsigned DWELL_W = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               load,
  input  logic               run,
  input  logic [DWELL_W-1:0] value,
  output logic               expire
);

  logic [DWELL_W-1:0] cnt_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= value;
    end else if (run && (cnt_q != '0)) begin
      cnt_q <= cnt_q - DWELL_W'(1);
    end
  end

  assign expire = run && (cnt_q == DWELL_W'(1));

endmodule

// File: rtl/decoder_scan_sequencer.sv
// Upstream driver for a 2x4 gate-level decoder. Steps the address 00..11 with a
// programmable dwell per address and blanks the decoder (enable=1) between
// addresses so that no two outputs are ever active together.
//   clock, reset : clock and asynchronous active-high reset
//   start, stop  : scan request (IDLE only) / abort (any state, wins over start)
//   single       : 1 = one pass then DONE, 0 = continuous (latched at start)
//   dwell        : ACTIVE cycles per address, 0 treated as 1 (latched at start)
//   A, B         : decoder address MSB/LSB (registered)
//   enable       : decoder enable, active-low (registered)
//   busy, done   : status (registered); done is a one-cycle pulse
//   pass_count   : completed 4-address passes since reset
module decoder_scan_sequencer
  import decoder_scan_sequencer_pkg::*;
#(
  parameter int unsigned DWELL_W = 4,
  parameter int unsigned PASS_W  = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic               single,
  input  logic [DWELL_W-1:0] dwell,
  output logic               A,
  output logic               B,
  output logic               enable,
  output logic               busy,
  output logic               done,
  output logic [PASS_W-1:0]  pass_count
);

  state_e             state_q, state_d;
  logic [1:0]         addr_q, addr_d;
  logic               single_q, single_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [PASS_W-1:0]  pass_q, pass_d;
  logic               enable_q, busy_q, done_q;
  logic               expire;

  // Timer is reloaded in the blanked cycle that precedes every ACTIVE window.
  decoder_scan_sequencer_dwell_timer #(
    .DWELL_W(DWELL_W)
  ) u_dwell_timer (
    .clock  (clock),
    .reset  (reset),
    .load   ((state_q == StSetup) || (state_q == StBlank)),
    .run    (state_q == StActive),
    .value  (dwell_q),
    .expire (expire)
  );

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    single_d = single_q;
    dwell_d  = dwell_q;
    pass_d   = pass_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d  = StSetup;
          addr_d   = 2'b00;
          single_d = single;
          dwell_d  = (dwell == '0) ? DWELL_W'(1) : dwell;
        end
      end
      StSetup: state_d = StActive;
      StActive: begin
        if (expire) begin
          if (addr_q != AddrLast) begin
            state_d = StBlank;
            addr_d  = addr_q + 2'd1;
          end else begin
            pass_d = pass_q + PASS_W'(1);
            if (single_q) begin
              state_d = StDone;
            end else begin
              state_d = StBlank;
              addr_d  = 2'b00;
            end
          end
        end
      end
      StBlank: state_d = StActive;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    // Abort overrides everything, including a pass completing this cycle.
    if (stop) begin
      state_d = StIdle;
      addr_d  = 2'b00;
      pass_d  = pass_q;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      addr_q   <= 2'b00;
      single_q <= 1'b0;
      dwell_q  <= DWELL_W'(1);
      pass_q   <= '0;
      enable_q <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      single_q <= single_d;
      dwell_q  <= dwell_d;
      pass_q   <= pass_d;
      // Status flops are decoded from the next state so they align with it.
      enable_q <= (state_d != StActive);
      busy_q   <= (state_d == StSetup) || (state_d == StActive) || (state_d == StBlank);
      done_q   <= (state_d == StDone);
    end
  end

  assign A          = addr_q[1];
  assign B          = addr_q[0];
  assign enable     = enable_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass_count = pass_q;

endmodule

// File: tb/tb_decoder_scan_sequencer.sv
module tb_decoder_scan_sequencer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       single = 1'b0;
  logic [3:0] dwell = 4'd0;
  logic       A, B, enable, busy, done;
  logic [7:0] pass_count;

  decoder_scan_sequencer #(
    .DWELL_W(4),
    .PASS_W (8)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .stop       (stop),
    .single     (single),
    .dwell      (dwell),
    .A          (A),
    .B          (B),
    .enable     (enable),
    .busy       (busy),
    .done       (done),
    .pass_count (pass_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [1:0] addr;
    logic       care_addr;
    logic       en;
    logic       busy;
    logic       done;
    logic [7:0] pc;
    int         test;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cur_test = 0;
  int   row_limit = 1000;
  logic [1:0] prev_addr = 2'b00;

  task automatic push_row(input int a, input int care, input int en, input int bsy,
                          input int dn, input int pc);
    exp_t e;
    if (row_limit > 0) begin
      e.addr = 2'(a); e.care_addr = 1'(care); e.en = 1'(en); e.busy = 1'(bsy);
      e.done = 1'(dn); e.pc = 8'(pc); e.test = cur_test;
      exp_q.push_back(e);
      row_limit--;
    end
  endtask

  // Expected cycle-by-cycle response starting with the SETUP cycle.
  task automatic push_scan(input int n, input int sgl, input int passes, input int pc0);
    int pc;
    int ne;
    pc = pc0;
    ne = (n == 0) ? 1 : n;
    push_row(0, 1, 1, 1, 0, pc);
    for (int p = 0; p < passes; p++) begin
      for (int a = 0; a < 4; a++) begin
        for (int i = 0; i < ne; i++) push_row(a, 1, 0, 1, 0, pc);
        if (a < 3) begin
          push_row(a + 1, 1, 1, 1, 0, pc);
        end else begin
          pc++;
          if (sgl != 0) begin
            push_row(3, 1, 1, 0, 1, pc);
            push_row(0, 0, 1, 0, 0, pc);
          end else begin
            push_row(0, 1, 1, 1, 0, pc);
          end
        end
      end
    end
  endtask

  // Waits until every expected row has been consumed; optionally drives junk
  // start/dwell/single while the scan is busy.
  task automatic wait_drain(input bit junk);
    int k;
    k = 0;
    while (exp_q.size() > 0 && k < 300) begin
      @(negedge clock);
      if (junk) begin
        start  = 1'($urandom_range(0, 1));
        dwell  = 4'($urandom_range(0, 15));
        single = 1'($urandom_range(0, 1));
      end else begin
        start = 1'b0;
      end
      k++;
    end
    start = 1'b0;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL t%0d drain_timeout: %0d rows still pending, required 0", cur_test,
               exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_now(input string name, input logic [12:0] got, input logic [12:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL t%0d %s: got {A,B,en,busy,done,pc}=%b, required %b", cur_test, name, got,
               req);
    end
  endtask

  // Scoreboard monitor: one expected row per cycle while rows are pending.
  always @(posedge clock) begin
    exp_t e;
    logic [12:0] got, req, mask;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      got  = {A, B, enable, busy, done, pass_count};
      req  = {e.addr, e.en, e.busy, e.done, e.pc};
      mask = {{2{e.care_addr}}, 11'h7ff};
      checks++;
      if ((got & mask) !== (req & mask)) begin
        errors++;
        $display("FAIL t%0d scan_row: got A,B=%b en=%b busy=%b done=%b pc=%0d, required A,B=%b%s en=%b busy=%b done=%b pc=%0d",
                 e.test, {A, B}, enable, busy, done, pass_count, e.addr,
                 e.care_addr ? "" : "(x)", e.en, e.busy, e.done, e.pc);
      end
    end
  end

  // Break-before-make: the address may only move while the decoder is blanked.
  always @(posedge clock) begin
    #1;
    if (!reset) begin
      checks++;
      if (({A, B} != prev_addr) && !enable) begin
        errors++;
        $display("FAIL t%0d addr_while_enabled: addr %b->%b with enable=%b, required enable=1",
                 cur_test, prev_addr, {A, B}, enable);
      end
    end
    prev_addr = {A, B};
  end

  initial begin
    // Reset state
    repeat (2) @(negedge clock);
    check_now("reset_state", {A, B, enable, busy, done, pass_count}, {2'b00, 3'b100, 8'd0});
    reset = 1'b0;

    // T2: single pass, dwell 2, DONE at cycle 13
    cur_test = 2;
    single = 1'b1; dwell = 4'd2; start = 1'b1;
    push_scan(2, 1, 1, 0);
    wait_drain(1'b0);

    // T3: dwell 0 treated as 1, DONE at cycle 9
    cur_test = 3;
    single = 1'b1; dwell = 4'd0; start = 1'b1;
    push_scan(0, 1, 1, 1);
    wait_drain(1'b0);

    // T4: continuous, dwell 3, two wraps, then stop in the wrap BLANK
    cur_test = 4;
    single = 1'b0; dwell = 4'd3; start = 1'b1;
    push_scan(3, 0, 2, 2);
    wait_drain(1'b0);
    stop = 1'b1;
    push_row(0, 1, 1, 0, 0, 4);
    @(negedge clock);
    stop = 1'b0;
    push_row(0, 1, 1, 0, 0, 4);
    wait_drain(1'b0);

    // T5: stop on first ACTIVE cycle of address 10, then restart from 00
    cur_test = 5;
    single = 1'b1; dwell = 4'd3; start = 1'b1;
    row_limit = 10;
    push_scan(3, 1, 1, 4);
    row_limit = 1000;
    wait_drain(1'b0);
    stop = 1'b1;
    push_row(0, 1, 1, 0, 0, 4);
    @(negedge clock);
    stop = 1'b0;
    wait_drain(1'b0);
    single = 1'b1; dwell = 4'd1; start = 1'b1;
    push_scan(1, 1, 1, 4);
    wait_drain(1'b0);

    // T6: start/dwell/single wiggled while busy; then start+stop in IDLE
    cur_test = 6;
    single = 1'b1; dwell = 4'd2; start = 1'b1;
    push_scan(2, 1, 1, 5);
    wait_drain(1'b1);
    start = 1'b1; stop = 1'b1;
    push_row(0, 1, 1, 0, 0, 6);
    push_row(0, 1, 1, 0, 0, 6);
    @(negedge clock);
    @(negedge clock);
    start = 1'b0; stop = 1'b0;
    wait_drain(1'b0);

    // T1: reset asserted mid-ACTIVE takes effect without a clock edge
    cur_test = 1;
    single = 1'b0; dwell = 4'd3; start = 1'b1;
    row_limit = 3;
    push_scan(3, 0, 1, 6);
    row_limit = 1000;
    wait_drain(1'b0);
    #2 reset = 1'b1;
    #1 check_now("async_reset", {A, B, enable, busy, done, pass_count}, {2'b00, 3'b100, 8'd0});
    @(negedge clock);
    reset = 1'b0;
    single = 1'b1; dwell = 4'd1; start = 1'b1;
    push_scan(1, 1, 1, 0);
    wait_drain(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
